// File: rtl/delay_event_gen.sv
// Programmable delayed-event generator: a start sampled at edge T makes evt_level
// sampled high at edge T+delay, matching nexttime[delay] semantics.
module delay_event_gen #(
    parameter int CNT_W  = 8,
    parameter int FCNT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  delay,
    input  logic              clear,
    output logic              evt_level,
    output logic              evt_pulse,
    output logic              busy,
    output logic [CNT_W-1:0]  cycles_left,
    output logic              overrun,
    output logic              zero_req,
    output logic [FCNT_W-1:0] fire_cnt
);

    typedef enum logic [1:0] {IDLE, ARMED, FIRED} state_t;

    state_t              state_reg, state_next;
    logic                evt_level_reg, evt_level_next;
    logic                evt_pulse_reg, evt_pulse_next;
    logic                busy_reg, busy_next;
    logic [CNT_W-1:0]    cycles_left_reg, cycles_left_next;
    logic                overrun_reg, overrun_next;
    logic                zero_req_reg, zero_req_next;
    logic [FCNT_W-1:0]   fire_cnt_reg, fire_cnt_next;

    logic accept_start;
    logic short_delay;
    logic count_done;

    assign accept_start = start && (state_reg != ARMED);
    // delay 0 is promoted to 1, so both fire on the start edge itself
    assign short_delay  = (delay <= CNT_W'(1));
    // the count is loaded with E at the start edge, so firing happens when it shows 2
    assign count_done   = (cycles_left_reg <= CNT_W'(2));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= IDLE;
            evt_level_reg   <= 1'b0;
            evt_pulse_reg   <= 1'b0;
            busy_reg        <= 1'b0;
            cycles_left_reg <= '0;
            overrun_reg     <= 1'b0;
            zero_req_reg    <= 1'b0;
            fire_cnt_reg    <= '0;
        end else begin
            state_reg       <= state_next;
            evt_level_reg   <= evt_level_next;
            evt_pulse_reg   <= evt_pulse_next;
            busy_reg        <= busy_next;
            cycles_left_reg <= cycles_left_next;
            overrun_reg     <= overrun_next;
            zero_req_reg    <= zero_req_next;
            fire_cnt_reg    <= fire_cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (clear) begin
            state_next = IDLE;
        end else if (accept_start) begin
            state_next = short_delay ? FIRED : ARMED;
        end else if (state_reg == ARMED && count_done) begin
            state_next = FIRED;
        end
    end

    always_comb begin
        evt_level_next   = evt_level_reg;
        evt_pulse_next   = 1'b0;
        cycles_left_next = cycles_left_reg;
        overrun_next     = overrun_reg;
        zero_req_next    = zero_req_reg;
        fire_cnt_next    = fire_cnt_reg;
        if (clear) begin
            evt_level_next   = 1'b0;
            cycles_left_next = '0;
            overrun_next     = 1'b0;
            zero_req_next    = 1'b0;
        end else if (accept_start) begin
            if (delay == '0) begin
                zero_req_next = 1'b1;
            end
            if (short_delay) begin
                evt_level_next   = 1'b1;
                evt_pulse_next   = 1'b1;
                cycles_left_next = '0;
                fire_cnt_next    = fire_cnt_reg + FCNT_W'(1);
            end else begin
                evt_level_next   = 1'b0;
                cycles_left_next = delay;
            end
        end else if (state_reg == ARMED) begin
            if (start) begin
                overrun_next = 1'b1;
            end
            if (count_done) begin
                evt_level_next   = 1'b1;
                evt_pulse_next   = 1'b1;
                cycles_left_next = '0;
                fire_cnt_next    = fire_cnt_reg + FCNT_W'(1);
            end else begin
                cycles_left_next = cycles_left_reg - CNT_W'(1);
            end
        end
        busy_next = (state_next == ARMED);
    end

    assign evt_level   = evt_level_reg;
    assign evt_pulse   = evt_pulse_reg;
    assign busy        = busy_reg;
    assign cycles_left = cycles_left_reg;
    assign overrun     = overrun_reg;
    assign zero_req    = zero_req_reg;
    assign fire_cnt    = fire_cnt_reg;

endmodule
